// File: rtl/injector_trim_cal.sv
// Closed-loop trim calibration for the bias/signal injector: SAR search of the
// pull-up and pull-down trim codes from synchronized comparators, then run-mode drive.
module injector_trim_cal #(
  parameter int SETTLE_CYCLES = 16,
  parameter int AVG_SAMPLES   = 8,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       sig_in,
  input  logic       cmp_p,
  input  logic       cmp_n,
  output logic [3:0] trim_p,
  output logic [3:0] trim_n,
  output logic       inj_enable,
  output logic       inj_signal,
  output logic       busy,
  output logic       done,
  output logic       fail
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    EN_SETTLE = 4'd1,
    P_SET     = 4'd2,
    P_WAIT    = 4'd3,
    P_SAMPLE  = 4'd4,
    P_DECIDE  = 4'd5,
    N_SET     = 4'd6,
    N_WAIT    = 4'd7,
    N_SAMPLE  = 4'd8,
    N_DECIDE  = 4'd9,
    RUN       = 4'd10
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(AVG_SAMPLES - 1);
  localparam logic [CNT_W:0]   AVG_THRESH  = (CNT_W + 1)'(AVG_SAMPLES);

  function automatic logic trim_saturated(input logic [3:0] code);
    return (code == 4'h0) || (code == 4'hF);
  endfunction

  state_t           state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt, ones_r, ones_nxt;
  logic [1:0]       bit_r, bit_nxt;
  logic [3:0]       trim_p_r, trim_p_nxt, trim_n_r, trim_n_nxt;
  logic [3:0]       bak_p_r, bak_p_nxt, bak_n_r, bak_n_nxt;
  logic             inj_enable_r, inj_enable_nxt, inj_signal_r, inj_signal_nxt;
  logic             busy_r, busy_nxt, done_r, done_nxt, fail_r, fail_nxt;
  logic             cmp_p_meta_r, cmp_p_sync_r, cmp_n_meta_r, cmp_n_sync_r;
  logic             calibrating_s, vote_s;

  // Two-flop synchronizers for the asynchronous comparator outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_p_meta_r <= 1'b0;
      cmp_p_sync_r <= 1'b0;
      cmp_n_meta_r <= 1'b0;
      cmp_n_sync_r <= 1'b0;
    end else begin
      cmp_p_meta_r <= cmp_p;
      cmp_p_sync_r <= cmp_p_meta_r;
      cmp_n_meta_r <= cmp_n;
      cmp_n_sync_r <= cmp_n_meta_r;
    end
  end

  // Next-state and next-output computation for the calibration sequencer
  always_comb begin
    state_nxt      = state_r;
    cnt_nxt        = cnt_r;
    ones_nxt       = ones_r;
    bit_nxt        = bit_r;
    trim_p_nxt     = trim_p_r;
    trim_n_nxt     = trim_n_r;
    bak_p_nxt      = bak_p_r;
    bak_n_nxt      = bak_n_r;
    inj_enable_nxt = inj_enable_r;
    inj_signal_nxt = inj_signal_r;
    busy_nxt       = busy_r;
    done_nxt       = 1'b0;
    fail_nxt       = fail_r;
    calibrating_s  = (state_r != IDLE) && (state_r != RUN);
    // Strict majority: a tie votes 0
    vote_s         = {ones_r, 1'b0} > AVG_THRESH;

    if (abort && calibrating_s) begin
      state_nxt      = IDLE;
      trim_p_nxt     = bak_p_r;
      trim_n_nxt     = bak_n_r;
      inj_enable_nxt = 1'b0;
      inj_signal_nxt = 1'b0;
      busy_nxt       = 1'b0;
    end else begin
      case (state_r)
        IDLE, RUN: begin
          if (abort) begin
            state_nxt      = IDLE;
            inj_enable_nxt = 1'b0;
            inj_signal_nxt = 1'b0;
          end else if (start) begin
            bak_p_nxt      = trim_p_r;
            bak_n_nxt      = trim_n_r;
            trim_p_nxt     = 4'h0;
            trim_n_nxt     = 4'h0;
            fail_nxt       = 1'b0;
            busy_nxt       = 1'b1;
            inj_enable_nxt = 1'b1;
            inj_signal_nxt = 1'b0;
            bit_nxt        = 2'd3;
            cnt_nxt        = {CNT_W{1'b0}};
            state_nxt      = EN_SETTLE;
          end else if (state_r == RUN) begin
            inj_signal_nxt = sig_in;
          end else begin
            inj_signal_nxt = 1'b0;
          end
        end
        EN_SETTLE, P_WAIT, N_WAIT: begin
          if (cnt_r == SETTLE_LAST) begin
            cnt_nxt  = {CNT_W{1'b0}};
            ones_nxt = {CNT_W{1'b0}};
            if (state_r == EN_SETTLE) begin
              state_nxt = P_SET;
            end else if (state_r == P_WAIT) begin
              state_nxt = P_SAMPLE;
            end else begin
              state_nxt = N_SAMPLE;
            end
          end else begin
            cnt_nxt = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        P_SET: begin
          trim_p_nxt[bit_r] = 1'b1;
          cnt_nxt           = {CNT_W{1'b0}};
          state_nxt         = P_WAIT;
        end
        N_SET: begin
          trim_n_nxt[bit_r] = 1'b1;
          cnt_nxt           = {CNT_W{1'b0}};
          state_nxt         = N_WAIT;
        end
        P_SAMPLE, N_SAMPLE: begin
          if (state_r == P_SAMPLE) begin
            ones_nxt = ones_r + {{(CNT_W-1){1'b0}}, cmp_p_sync_r};
          end else begin
            ones_nxt = ones_r + {{(CNT_W-1){1'b0}}, cmp_n_sync_r};
          end
          if (cnt_r == SAMPLE_LAST) begin
            cnt_nxt   = {CNT_W{1'b0}};
            state_nxt = (state_r == P_SAMPLE) ? P_DECIDE : N_DECIDE;
          end else begin
            cnt_nxt = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        P_DECIDE: begin
          if (vote_s) begin
            trim_p_nxt[bit_r] = 1'b0;
          end else begin
            trim_p_nxt = trim_p_r;
          end
          if (bit_r == 2'd0) begin
            bit_nxt   = 2'd3;
            state_nxt = N_SET;
          end else begin
            bit_nxt   = bit_r - 2'd1;
            state_nxt = P_SET;
          end
        end
        N_DECIDE: begin
          // Pull-down sense is inverted: a low comparator means excess pull-down
          if (!vote_s) begin
            trim_n_nxt[bit_r] = 1'b0;
          end else begin
            trim_n_nxt = trim_n_r;
          end
          if (bit_r == 2'd0) begin
            state_nxt = RUN;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            fail_nxt  = trim_saturated(trim_p_nxt) || trim_saturated(trim_n_nxt);
          end else begin
            bit_nxt   = bit_r - 2'd1;
            state_nxt = N_SET;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      ones_r       <= {CNT_W{1'b0}};
      bit_r        <= 2'd3;
      trim_p_r     <= 4'h8;
      trim_n_r     <= 4'h8;
      bak_p_r      <= 4'h8;
      bak_n_r      <= 4'h8;
      inj_enable_r <= 1'b0;
      inj_signal_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      fail_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      cnt_r        <= cnt_nxt;
      ones_r       <= ones_nxt;
      bit_r        <= bit_nxt;
      trim_p_r     <= trim_p_nxt;
      trim_n_r     <= trim_n_nxt;
      bak_p_r      <= bak_p_nxt;
      bak_n_r      <= bak_n_nxt;
      inj_enable_r <= inj_enable_nxt;
      inj_signal_r <= inj_signal_nxt;
      busy_r       <= busy_nxt;
      done_r       <= done_nxt;
      fail_r       <= fail_nxt;
    end
  end

  assign trim_p     = trim_p_r;
  assign trim_n     = trim_n_r;
  assign inj_enable = inj_enable_r;
  assign inj_signal = inj_signal_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign fail       = fail_r;

endmodule

// File: tb/tb_injector_trim_cal.sv
// Scoreboarded bench for injector_trim_cal: threshold comparator models drive the
// SAR search, expected results are queued at start and checked when done pulses.
module tb_injector_trim_cal;

  localparam int LAT = 16 + 8 * (16 + 8 + 2);

  logic clk = 1'b0;
  logic rst_n, start, abort, sig_in, cmp_p, cmp_n;
  logic [3:0] trim_p, trim_n;
  logic inj_enable, inj_signal, busy, done, fail;

  int  thr_p, thr_n;
  logic p_force_mode, p_force;

  typedef struct { int tp; int tn; int fl; int cyc; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0, n_fail = 0, cyc = 0, done_cnt = 0, busy_cnt = 0;

  always #5 clk = ~clk;

  // Comparator models: p trips at/above thr_p, n reads high while below thr_n
  assign cmp_p = p_force_mode ? p_force : (int'(trim_p) >= thr_p);
  assign cmp_n = (int'(trim_n) < thr_n);

  injector_trim_cal dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sig_in(sig_in),
    .cmp_p(cmp_p), .cmp_n(cmp_n), .trim_p(trim_p), .trim_n(trim_n),
    .inj_enable(inj_enable), .inj_signal(inj_signal), .busy(busy),
    .done(done), .fail(fail)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // A monotonic threshold comparator leaves the SAR on the largest code below it
  function automatic int sar_ref(input int thr);
    if (thr <= 0) return 0;
    else if (thr >= 16) return 15;
    else return thr - 1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: every done pulse consumes one expected record
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done pulse at cycle %0d with nothing expected", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_trim_p", int'(trim_p), e.tp);
          check("done_trim_n", int'(trim_n), e.tn);
          check("done_fail", int'(fail), e.fl);
          check("done_cycle", cyc, e.cyc);
          check("busy_length", busy_cnt, LAT);
          check("done_busy_low", int'(busy), 0);
        end
        busy_cnt = 0;
      end else if (busy) begin
        busy_cnt++;
      end else begin
        busy_cnt = 0;
      end
    end
  end

  // Pulse start and queue the expected result; returns at the negedge after the start edge
  task automatic cal(input int tp_thr, input int tn_thr, input int exp_tp, input int exp_tn);
    exp_t e;
    thr_p = tp_thr;
    thr_n = tn_thr;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e.tp  = exp_tp;
    e.tn  = exp_tn;
    e.fl  = (exp_tp == 0 || exp_tp == 15 || exp_tn == 0 || exp_tn == 15) ? 1 : 0;
    e.cyc = cyc + LAT;
    exp_q.push_back(e);
    check("start_busy", int'(busy), 1);
    check("start_fail_clr", int'(fail), 0);
    check("start_trims", int'({trim_p, trim_n}), 0);
    check("start_enable", int'(inj_enable), 1);
  endtask

  task automatic wait_done(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end
  endtask

  initial begin
    int dc, hi, prev;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sig_in = 1'b0;
    thr_p = 6; thr_n = 10; p_force_mode = 1'b0; p_force = 1'b0;
    #12;
    check("rst_trim_p", int'(trim_p), 8);
    check("rst_trim_n", int'(trim_n), 8);
    check("rst_outputs", int'({inj_enable, inj_signal, busy, done, fail}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Nominal calibration
    cal(6, 10, 5, 9);
    wait_done(LAT + 10);

    // RUN passthrough: one register of delay on sig_in
    prev = int'(inj_signal);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sig_in = (k % 2 == 0) ? 1'b1 : 1'b0;
      #1 check("sig_not_comb", int'(inj_signal), prev);
      @(negedge clk);
      check("sig_delayed", int'(inj_signal), int'(sig_in));
      prev = int'(sig_in);
    end
    check("run_enable", int'(inj_enable), 1);

    // Saturation, twice: second start clears fail, done sets it again
    cal(16, 10, 15, 9);
    wait_done(LAT + 10);
    cal(16, 10, 15, 9);
    wait_done(LAT + 10);

    // Majority vote on the MSB: raw samples reach the vote window at edges 32..39
    for (int v = 0; v < 2; v++) begin
      hi = (v == 0) ? 4 : 5;
      p_force_mode = 1'b1;
      p_force = 1'b0;
      cal(6, 10, (2 * hi > 8) ? 7 : 15, 9);
      for (int k = 1; k <= 60; k++) begin
        p_force = (k >= 33 && k <= 32 + hi) ? 1'b1 : 1'b0;
        @(negedge clk);
      end
      p_force = 1'b0;
      wait_done(LAT);
      p_force_mode = 1'b0;
    end

    // Abort mid-calibration from RUN with trims 5/9
    cal(6, 10, 5, 9);
    wait_done(LAT + 10);
    cal(6, 10, 5, 9);
    repeat (99) @(negedge clk);
    exp_q.delete();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_trim_p", int'(trim_p), 5);
    check("abort_trim_n", int'(trim_n), 9);
    check("abort_outputs", int'({inj_enable, inj_signal, busy, done}), 0);
    dc = done_cnt;
    repeat (LAT) @(negedge clk);
    check("abort_no_done", done_cnt, dc);

    // start and abort together in RUN: abort wins
    cal(6, 10, 5, 9);
    wait_done(LAT + 10);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("both_busy", int'(busy), 0);
    check("both_enable", int'(inj_enable), 0);
    check("both_trims", int'({trim_p, trim_n}), 8'h59);
    dc = done_cnt;
    repeat (LAT + 20) @(negedge clk);
    check("both_no_done", done_cnt, dc);
    check("both_idle_busy", int'(busy), 0);

    // Asynchronous reset mid-calibration, then a clean restart
    cal(6, 10, 5, 9);
    repeat (49) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_trim_p", int'(trim_p), 8);
    check("mid_rst_trim_n", int'(trim_n), 8);
    check("mid_rst_outputs", int'({inj_enable, busy, fail}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cal(6, 10, 5, 9);
    wait_done(LAT + 10);

    // start pulses while busy must not disturb the search or its timing
    cal(6, 10, 5, 9);
    repeat (39) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (110) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(LAT);

    // Randomized thresholds against the closed-form SAR result
    for (int r = 0; r < 6; r++) begin
      int tp, tn;
      tp = int'($urandom_range(0, 16));
      tn = int'($urandom_range(0, 16));
      cal(tp, tn, sar_ref(tp), sar_ref(tn));
      wait_done(LAT + 10);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
